multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for a 16-bit load/store core.
// Sequences fetch, decode, execute, memory and writeback states.
module multicycle_control_unit #(
  parameter int WAIT_LIMIT = 8,
  parameter int WAIT_BITS  = 4,
  parameter int SHAMT_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            opCode1,
  input  logic [3:0]            opCode2,
  input  logic [3:0]            conditionCode,
  input  logic [7:0]            PSR,
  input  logic [SHAMT_BITS-1:0] shiftAmtIn,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ir_en,
  output logic                  imm_en,
  output logic                  psr_en,
  output logic                  result_en,
  output logic                  reg_wr_en,
  output logic                  link_en,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  addr_sel,
  output logic                  src_b_sel,
  output logic                  zero_extend,
  output logic [3:0]            alu_ctrl,
  output logic [3:0]            shift_ctrl,
  output logic [1:0]            result_sel,
  output logic [1:0]            pc_src,
  output logic [SHAMT_BITS-1:0] shiftAmtOut,
  output logic                  bus_error,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    RTYPEEX = 4'd2,
    ITYPEEX = 4'd3,
    SHIFTEX = 4'd4,
    WB      = 4'd5,
    MEMADR  = 4'd6,
    LDRD    = 4'd7,
    LDWR    = 4'd8,
    STWR    = 4'd9,
    BREX    = 4'd10,
    JEX     = 4'd11,
    HALT    = 4'd12
  } state_t;

  state_t               state_q, state_d;
  logic [WAIT_BITS-1:0] wait_q, wait_d;
  logic                 berr_q, berr_d;

  logic c_f, l_f, f_f, z_f, n_f;
  logic unused_psr;
  logic cond_true;
  logic is_cmp;
  logic is_jal;
  logic mem_wait;
  logic at_limit;

  assign c_f = PSR[0];
  assign l_f = PSR[2];
  assign f_f = PSR[5];
  assign z_f = PSR[6];
  assign n_f = PSR[7];
  assign unused_psr = ^{PSR[4:3], PSR[1]};

  assign is_cmp = (opCode1 == 4'hB) ||
                  (opCode1 == 4'h0 && opCode2 == 4'hB);
  assign is_jal = (opCode2 == 4'h8);

  assign mem_wait = (state_q == FETCH) ||
                    (state_q == LDRD)  ||
                    (state_q == STWR);
  assign at_limit = (wait_q == WAIT_BITS'(WAIT_LIMIT));

  assign shiftAmtOut = shiftAmtIn;
  assign bus_error   = berr_q;
  assign state_o     = state_q;

  always_comb begin
    cond_true = 1'b0;
    unique case (conditionCode)
      4'h0: cond_true = z_f;
      4'h1: cond_true = !z_f;
      4'h2: cond_true = c_f;
      4'h3: cond_true = !c_f;
      4'h4: cond_true = l_f;
      4'h5: cond_true = !l_f;
      4'h6: cond_true = n_f;
      4'h7: cond_true = !n_f;
      4'h8: cond_true = f_f;
      4'h9: cond_true = !f_f;
      4'hA: cond_true = !l_f && !z_f;
      4'hB: cond_true = l_f || z_f;
      4'hC: cond_true = !n_f && !z_f;
      4'hD: cond_true = n_f || z_f;
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
    endcase
  end

  // Next state, wait counter and sticky bus error
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    berr_d  = berr_q;
    case (state_q)
      FETCH: begin
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        case (opCode1)
          4'h0: state_d = RTYPEEX;
          4'h1, 4'h2, 4'h3, 4'h5,
          4'h9, 4'hB, 4'hD: state_d = ITYPEEX;
          4'h8, 4'hF: state_d = SHIFTEX;
          4'hC: state_d = BREX;
          4'h4: begin
            case (opCode2)
              4'h0, 4'h4: state_d = MEMADR;
              4'h8, 4'hC: state_d = JEX;
              default:    state_d = FETCH;
            endcase
          end
          default: state_d = FETCH;
        endcase
      end
      RTYPEEX, ITYPEEX, SHIFTEX: state_d = WB;
      WB:     state_d = FETCH;
      MEMADR: state_d = (opCode2 == 4'h0) ? LDRD : STWR;
      LDRD: begin
        if (mem_ready) state_d = LDWR;
      end
      LDWR: state_d = FETCH;
      STWR: begin
        if (mem_ready) state_d = FETCH;
      end
      BREX, JEX: state_d = FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
    // A memory state waiting at the limit gives up and halts
    if (mem_wait && !mem_ready) begin
      if (at_limit) begin
        state_d = HALT;
        berr_d  = 1'b1;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    imm_en      = 1'b0;
    psr_en      = 1'b0;
    result_en   = 1'b0;
    reg_wr_en   = 1'b0;
    link_en     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    addr_sel    = 1'b0;
    src_b_sel   = 1'b1;
    zero_extend = 1'b1;
    alu_ctrl    = 4'h5;
    shift_ctrl  = 4'h0;
    result_sel  = 2'd1;
    pc_src      = 2'd0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          mem_rd = 1'b1;
          ir_en  = mem_ready;
          pc_en  = mem_ready;
        end
        DECODE: begin
          imm_en      = 1'b1;
          src_b_sel   = 1'b0;
          zero_extend = (opCode1 == 4'h1) ||
                        (opCode1 == 4'h2) ||
                        (opCode1 == 4'h3) ||
                        (opCode1 == 4'hD);
        end
        RTYPEEX: begin
          alu_ctrl  = opCode2;
          psr_en    = 1'b1;
          result_en = 1'b1;
        end
        ITYPEEX: begin
          alu_ctrl  = opCode1;
          src_b_sel = 1'b0;
          psr_en    = 1'b1;
          result_en = 1'b1;
        end
        SHIFTEX: begin
          result_sel = 2'd0;
          result_en  = 1'b1;
          if (opCode1 == 4'hF) begin
            shift_ctrl = 4'hF;
            src_b_sel  = 1'b0;
          end else begin
            shift_ctrl = opCode2;
            src_b_sel  = (opCode2 == 4'h4);
          end
        end
        WB: reg_wr_en = !is_cmp;
        MEMADR: addr_sel = 1'b1;
        LDRD: begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
        end
        LDWR: begin
          result_sel = 2'd2;
          reg_wr_en  = 1'b1;
        end
        STWR: begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end
        BREX: begin
          if (cond_true) begin
            pc_en  = 1'b1;
            pc_src = 2'd1;
          end
        end
        JEX: begin
          if (cond_true || is_jal) begin
            pc_en  = 1'b1;
            pc_src = 2'd2;
          end
          if (is_jal) begin
            reg_wr_en  = 1'b1;
            link_en    = 1'b1;
            result_sel = 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      berr_q  <= berr_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit.
// Per-cycle expected output vectors are queued and checked at negedge.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en;
    logic       ir_en;
    logic       imm_en;
    logic       psr_en;
    logic       result_en;
    logic       reg_wr_en;
    logic       link_en;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       src_b_sel;
    logic       zero_extend;
    logic [3:0] alu;
    logic [3:0] sh;
    logic [1:0] rsel;
    logic [1:0] psrc;
    logic       berr;
    logic [3:0] sha;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] opCode1, opCode2, conditionCode;
  logic [7:0] PSR;
  logic [3:0] shiftAmtIn;
  logic       mem_ready;
  logic       pc_en, ir_en, imm_en, psr_en, result_en;
  logic       reg_wr_en, link_en, mem_rd, mem_wr;
  logic       addr_sel, src_b_sel, zero_extend;
  logic [3:0] alu_ctrl, shift_ctrl;
  logic [1:0] result_sel, pc_src;
  logic [3:0] shiftAmtOut;
  logic       bus_error;
  logic [3:0] state_o;

  int n_chk = 0;
  int n_err = 0;
  logic berr_exp = 1'b0;

  exp_t  exp_q[$];
  string tag_q[$];

  multicycle_control_unit #(
    .WAIT_LIMIT(8), .WAIT_BITS(4), .SHAMT_BITS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .opCode1(opCode1), .opCode2(opCode2),
    .conditionCode(conditionCode), .PSR(PSR),
    .shiftAmtIn(shiftAmtIn), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_en(ir_en), .imm_en(imm_en),
    .psr_en(psr_en), .result_en(result_en),
    .reg_wr_en(reg_wr_en), .link_en(link_en),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr_sel(addr_sel), .src_b_sel(src_b_sel),
    .zero_extend(zero_extend),
    .alu_ctrl(alu_ctrl), .shift_ctrl(shift_ctrl),
    .result_sel(result_sel), .pc_src(pc_src),
    .shiftAmtOut(shiftAmtOut), .bus_error(bus_error),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t  o;
    exp_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {state_o, pc_en, ir_en, imm_en, psr_en,
           result_en, reg_wr_en, link_en, mem_rd,
           mem_wr, addr_sel, src_b_sel, zero_extend,
           alu_ctrl, shift_ctrl, result_sel, pc_src,
           bus_error, shiftAmtOut};
      chk(t, {31'd0, o}, {31'd0, e});
    end
  end

  function automatic exp_t dv(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.src_b_sel = 1'b1;
    e.zero_extend = 1'b1;
    e.alu = 4'h5;
    e.rsel = 2'd1;
    e.berr = berr_exp;
    return e;
  endfunction

  task automatic step(input string tag, input logic rdy,
                      input exp_t e_in);
    exp_t e;
    e = e_in;
    mem_ready = rdy;
    shiftAmtIn = 4'($urandom);
    e.sha = shiftAmtIn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag);
    exp_t e;
    e = dv(4'd0);
    e.mem_rd = 1'b1;
    e.ir_en = 1'b1;
    e.pc_en = 1'b1;
    step({tag, "_if"}, 1'b1, e);
  endtask

  task automatic fetch_wait(input string tag);
    exp_t e;
    e = dv(4'd0);
    e.mem_rd = 1'b1;
    step({tag, "_ifw"}, 1'b0, e);
  endtask

  task automatic decode(input string tag, input logic ze);
    exp_t e;
    e = dv(4'd1);
    e.imm_en = 1'b1;
    e.src_b_sel = 1'b0;
    e.zero_extend = ze;
    step({tag, "_id"}, 1'b1, e);
  endtask

  task automatic wb(input string tag, input logic wr);
    exp_t e;
    e = dv(4'd5);
    e.reg_wr_en = wr;
    step({tag, "_wb"}, 1'b1, e);
  endtask

  task automatic itype(input string tag, input logic [3:0] op1,
                       input logic ze, input logic wr);
    exp_t e;
    opCode1 = op1;
    opCode2 = 4'h7;
    fetch_ok(tag);
    decode(tag, ze);
    e = dv(4'd3);
    e.alu = op1;
    e.src_b_sel = 1'b0;
    e.psr_en = 1'b1;
    e.result_en = 1'b1;
    step({tag, "_ex"}, 1'b1, e);
    wb(tag, wr);
  endtask

  task automatic rtype(input string tag, input logic [3:0] op2,
                       input logic wr);
    exp_t e;
    opCode1 = 4'h0;
    opCode2 = op2;
    fetch_ok(tag);
    decode(tag, 1'b0);
    e = dv(4'd2);
    e.alu = op2;
    e.psr_en = 1'b1;
    e.result_en = 1'b1;
    step({tag, "_ex"}, 1'b1, e);
    wb(tag, wr);
  endtask

  task automatic shift(input string tag, input logic [3:0] op1,
                       input logic [3:0] op2, input logic [3:0] sh,
                       input logic srcb);
    exp_t e;
    opCode1 = op1;
    opCode2 = op2;
    fetch_ok(tag);
    decode(tag, 1'b0);
    e = dv(4'd4);
    e.rsel = 2'd0;
    e.result_en = 1'b1;
    e.sh = sh;
    e.src_b_sel = srcb;
    step({tag, "_ex"}, 1'b1, e);
    wb(tag, 1'b1);
  endtask

  task automatic branch(input string tag, input logic [3:0] cc,
                        input logic [7:0] psr, input logic taken);
    exp_t e;
    opCode1 = 4'hC;
    opCode2 = 4'h0;
    conditionCode = cc;
    PSR = psr;
    fetch_ok(tag);
    decode(tag, 1'b0);
    e = dv(4'd10);
    if (taken) begin
      e.pc_en = 1'b1;
      e.psrc = 2'd1;
    end
    step({tag, "_br"}, 1'b1, e);
  endtask

  task automatic jump(input string tag, input logic [3:0] op2,
                      input logic [3:0] cc, input logic [7:0] psr,
                      input logic taken, input logic link);
    exp_t e;
    opCode1 = 4'h4;
    opCode2 = op2;
    conditionCode = cc;
    PSR = psr;
    fetch_ok(tag);
    decode(tag, 1'b0);
    e = dv(4'd11);
    if (taken) begin
      e.pc_en = 1'b1;
      e.psrc = 2'd2;
    end
    if (link) begin
      e.reg_wr_en = 1'b1;
      e.link_en = 1'b1;
      e.rsel = 2'd3;
    end
    step({tag, "_j"}, 1'b1, e);
  endtask

  task automatic mem_op(input string tag, input logic store,
                        input int nwait);
    exp_t e;
    opCode1 = 4'h4;
    opCode2 = store ? 4'h4 : 4'h0;
    fetch_ok(tag);
    decode(tag, 1'b0);
    e = dv(4'd6);
    e.addr_sel = 1'b1;
    step({tag, "_ma"}, 1'b1, e);
    e = dv(store ? 4'd9 : 4'd7);
    e.addr_sel = 1'b1;
    e.mem_rd = !store;
    e.mem_wr = store;
    for (int i = 0; i < nwait; i++)
      step({tag, "_mw"}, 1'b0, e);
    step({tag, "_mr"}, 1'b1, e);
    if (!store) begin
      e = dv(4'd8);
      e.rsel = 2'd2;
      e.reg_wr_en = 1'b1;
      step({tag, "_ldwr"}, 1'b1, e);
    end
  endtask

  task automatic bad_op(input string tag, input logic [3:0] op1,
                        input logic [3:0] op2);
    opCode1 = op1;
    opCode2 = op2;
    fetch_ok(tag);
    decode(tag, 1'b0);
  endtask

  task automatic do_reset(input string tag, input logic [3:0] st);
    exp_t e;
    reset = 1'b1;
    e = dv(st);
    step(tag, 1'b1, e);
    reset = 1'b0;
    berr_exp = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    opCode1 = 4'h0;
    opCode2 = 4'h0;
    conditionCode = 4'h0;
    PSR = 8'h00;
    shiftAmtIn = 4'h0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("rst", 4'd0);

    itype("addi", 4'h5, 1'b0, 1'b1);
    itype("cmpi", 4'hB, 1'b0, 1'b0);
    itype("andi", 4'h1, 1'b1, 1'b1);
    itype("xori", 4'hD, 1'b1, 1'b1);
    rtype("add", 4'h3, 1'b1);
    rtype("cmp", 4'hB, 1'b0);
    shift("lsh", 4'h8, 4'h4, 4'h4, 1'b1);
    shift("lshi", 4'h8, 4'h0, 4'h0, 1'b0);
    shift("ashui", 4'hF, 4'h2, 4'hF, 1'b0);

    branch("beq_t", 4'h0, 8'h40, 1'b1);
    branch("beq_n", 4'h0, 8'h00, 1'b0);
    branch("bhi_t", 4'hA, 8'h00, 1'b1);
    branch("bls_t", 4'hB, 8'h04, 1'b1);
    branch("bgt_n", 4'hC, 8'h40, 1'b0);
    branch("ble_t", 4'hD, 8'h80, 1'b1);
    branch("bfs_t", 4'h8, 8'h20, 1'b1);
    branch("bcc_n", 4'h3, 8'h01, 1'b0);
    branch("buc_t", 4'hE, 8'h00, 1'b1);
    branch("bnv_n", 4'hF, 8'hFF, 1'b0);

    jump("jal", 4'h8, 4'hF, 8'h00, 1'b1, 1'b1);
    jump("jne_t", 4'hC, 4'h1, 8'h00, 1'b1, 1'b0);
    jump("jnv_n", 4'hC, 4'hF, 8'h00, 1'b0, 1'b0);

    mem_op("load0", 1'b0, 0);
    mem_op("load3", 1'b0, 3);
    mem_op("stor0", 1'b0 ^ 1'b1, 0);
    mem_op("stor2", 1'b1, 2);

    bad_op("bad4", 4'h4, 4'h1);
    bad_op("bad6", 4'h6, 4'h0);

    opCode1 = 4'h6;
    for (int i = 0; i < 8; i++) fetch_wait("lim");
    fetch_ok("lim");
    decode("lim", 1'b0);

    for (int i = 0; i < 9; i++) fetch_wait("tmo");
    berr_exp = 1'b1;
    e = dv(4'd12);
    step("halt0", 1'b1, e);
    step("halt1", 1'b0, e);
    do_reset("rst_halt", 4'd12);
    fetch_ok("post_halt");
    decode("post_halt", 1'b0);

    opCode1 = 4'h4;
    opCode2 = 4'h0;
    fetch_ok("midw");
    decode("midw", 1'b0);
    e = dv(4'd6);
    e.addr_sel = 1'b1;
    step("midw_ma", 1'b1, e);
    e = dv(4'd7);
    e.addr_sel = 1'b1;
    e.mem_rd = 1'b1;
    step("midw_w0", 1'b0, e);
    step("midw_w1", 1'b0, e);
    do_reset("rst_midw", 4'd7);
    itype("after_rst", 4'h5, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0)
      chk("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=stalled want=finish");
    $fatal(1, "timeout");
  end

endmodule
